// File: rtl/ring_eject_port_pkg.sv
// Network-wide shared definitions for the ring interconnect: id/data widths and the packet format.
package ring_eject_port_pkg;

  localparam int ID_SIZE    = 4;
  localparam int DATA_WIDTH = 8;
  localparam int NUMNODES   = 4;

  // Packed MSB to LSB: src, dest, data.
  typedef struct packed {
    logic [ID_SIZE-1:0]    src;
    logic [ID_SIZE-1:0]    dest;
    logic [DATA_WIDTH-1:0] data;
  } pkt_t;

endpackage

// File: rtl/ring_eject_port_if.sv
// Upstream link, downstream link and core handshakes of one ring node, plus status outputs.
interface ring_eject_port_if;
  import ring_eject_port_pkg::*;

  logic        ring_in_valid;
  pkt_t        ring_in_pkt;
  logic        ring_in_ready;
  logic        ring_out_valid;
  pkt_t        ring_out_pkt;
  logic        ring_out_ready;
  logic        core_valid;
  pkt_t        core_pkt;
  logic        core_ready;
  logic        recieved;
  logic        full;
  logic        drop;
  logic [15:0] bounce_count;

  // slave: the eject stage itself; master: the surrounding ring, core and status observer.
  modport slave (
    input  ring_in_valid, ring_in_pkt, ring_out_ready, core_ready,
    output ring_in_ready, ring_out_valid, ring_out_pkt, core_valid, core_pkt,
    output recieved, full, drop, bounce_count
  );

  modport master (
    output ring_in_valid, ring_in_pkt, ring_out_ready, core_ready,
    input  ring_in_ready, ring_out_valid, ring_out_pkt, core_valid, core_pkt,
    input  recieved, full, drop, bounce_count
  );

endinterface

// File: rtl/ring_eject_fifo.sv
// Circular pkt_t queue feeding the core. Pointers wrap modulo DEPTH; full/empty come from the count.
module ring_eject_fifo
  import ring_eject_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  pkt_t wr_pkt_i,
  input  logic pop_i,
  output pkt_t rd_pkt_o,
  output logic full_o,
  output logic empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  pkt_t          mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);

  // Full is the pre-pop state, so a same-cycle pop never makes room for a push.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wr_pkt_i;
  end

  assign rd_pkt_o = mem_q[rd_q];

endmodule

// File: rtl/ring_eject_port.sv
// Ring node eject stage: classifies upstream packets into the core queue, the forward register or a drop.
module ring_eject_port
  import ring_eject_port_pkg::*;
#(
  parameter int NODE_ID   = 0,
  parameter int NUM_NODES = 4,
  parameter int DEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  ring_eject_port_if.slave  bus
);

  logic        fwd_vld_q, fwd_vld_d;
  pkt_t        fwd_pkt_q, fwd_pkt_d;
  logic        recv_q, recv_d;
  logic        drop_q, drop_d;
  logic [15:0] bnc_q, bnc_d;

  logic q_full, q_empty, push, pop, accept, dest_oor, dest_here;
  pkt_t q_head;

  // Every packet type waits on the forward register, so deflection never needs extra buffering.
  assign bus.ring_in_ready = !rst && (!fwd_vld_q || bus.ring_out_ready);
  assign accept            = bus.ring_in_valid && bus.ring_in_ready;
  assign dest_oor          = 32'(bus.ring_in_pkt.dest) >= 32'(NUM_NODES);
  assign dest_here         = 32'(bus.ring_in_pkt.dest) == 32'(NODE_ID);
  assign pop               = !q_empty && bus.core_ready;

  always_comb begin
    fwd_vld_d = fwd_vld_q && !bus.ring_out_ready;
    fwd_pkt_d = fwd_pkt_q;
    push      = 1'b0;
    recv_d    = 1'b0;
    drop_d    = 1'b0;
    bnc_d     = bnc_q;
    if (accept) begin
      if (dest_oor) begin
        drop_d = 1'b1;
      end else if (dest_here && !q_full) begin
        push   = 1'b1;
        recv_d = 1'b1;
      end else begin
        fwd_vld_d = 1'b1;
        fwd_pkt_d = bus.ring_in_pkt;
        if (dest_here && bnc_q != 16'hFFFF) bnc_d = bnc_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_vld_q <= 1'b0;
      fwd_pkt_q <= '0;
      recv_q    <= 1'b0;
      drop_q    <= 1'b0;
      bnc_q     <= '0;
    end else begin
      fwd_vld_q <= fwd_vld_d;
      fwd_pkt_q <= fwd_pkt_d;
      recv_q    <= recv_d;
      drop_q    <= drop_d;
      bnc_q     <= bnc_d;
    end
  end

  ring_eject_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .wr_pkt_i (bus.ring_in_pkt),
    .pop_i    (pop),
    .rd_pkt_o (q_head),
    .full_o   (q_full),
    .empty_o  (q_empty)
  );

  assign bus.ring_out_valid = fwd_vld_q;
  assign bus.ring_out_pkt   = fwd_pkt_q;
  assign bus.core_valid     = !q_empty;
  assign bus.core_pkt       = q_head;
  assign bus.recieved       = recv_q;
  assign bus.drop           = drop_q;
  assign bus.full           = q_full;
  assign bus.bounce_count   = bnc_q;

endmodule
